alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001: clk  input  1  single clock; all state updates on its rising edge.
REQ-002: rst  input  1  reset, asynchronous, active-high.
REQ-003: cmd_valid  input  1  command request.
REQ-004: cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a rising clk edge.
REQ-005: cmd_op  input  4  ALU opcode; 4'b1000 = LOAD (sequencer-local).
REQ-006: cmd_rd, cmd_ra, cmd_rb  input  2 each  destination / operand-A / operand-B register index.
REQ-007: cmd_imm  input  4  immediate for LOAD.
REQ-008: alu_a, alu_b  output  4 each  operands driven to the external ALU.
REQ-009: alu_s  output  4  opcode driven to the external ALU.
REQ-010: alu_res  input  5  combinational ALU result, valid in the same cycle as alu_a/alu_b/alu_s.
REQ-011: rsp_valid  output  1  response available.
REQ-012: rsp_ready  input  1  response consumed when rsp_valid && rsp_ready at a rising clk edge.
REQ-013: rsp_data  output  5  result of the completed command.

Function
REQ-014: The block SHALL hold a 4-entry x 4-bit register file rf[0..3].
REQ-015: FSM states SHALL be IDLE, EXEC, RESP.
REQ-016: cmd_ready SHALL equal 1 only in IDLE with rst low; 0 in EXEC and RESP.
REQ-017: IDLE, accepted cmd_op != 4'b1000 -> latch op/rd/ra/rb, go to EXEC.
REQ-018: IDLE, accepted cmd_op == 4'b1000 -> rf[rd] <= cmd_imm, rsp_data <= {1'b0, cmd_imm}, go to RESP; the ALU is not issued.
REQ-019: EXEC (exactly one cycle) SHALL drive alu_a = rf[ra], alu_b = rf[rb], alu_s = latched op.
REQ-020: At the EXEC->RESP edge: rsp_data <= alu_res (all 5 bits), rf[rd] <= alu_res[3:0].
REQ-021: Outside EXEC: alu_a = 0, alu_b = 0, alu_s = 4'b1111.
REQ-022: RESP: rsp_valid = 1, rsp_data stable until handshake; on handshake go to IDLE.
REQ-023: Latency: command accepted at edge T -> rsp_valid high from edge T+2 (ALU ops) or T+1 (LOAD); minimum 3 cycles per ALU command, 2 per LOAD.
REQ-024: Operands SHALL be read before write-back; ra == rd or rb == rd uses the pre-command value.
REQ-025: rsp_ready held low SHALL stall indefinitely with rsp_valid/rsp_data/rf unchanged; cmd_valid ignored.
REQ-026: rsp_ready asserted outside RESP SHALL have no effect.
REQ-027: Opcodes 4'b0000-4'b0111 and 4'b1001-4'b1111 SHALL be issued unmodified; no result interpretation beyond REQ-020.

Reset
REQ-028: rst high SHALL immediately force state IDLE, rf[0..3] = 0, rsp_valid = 0, rsp_data = 0, cmd_ready = 0, alu_a = 0, alu_b = 0, alu_s = 4'b1111.
REQ-029: Reset during EXEC or RESP SHALL abort the command with no write-back and no response.
REQ-030: First command may be accepted on the first rising edge after rst deasserts.

Structure
REQ-031: Opcode constants (OP_ADD=0000 ... OP_LOAD=1000 ... OP_ZERO=1111) and the FSM state encoding SHALL live in the shared package alu_seq_pkg.
REQ-032: The register file SHALL be a sub-module seq_regfile (4x4, two async read ports, one sync write port, async reset).
REQ-033: The ALU SHALL remain external; the bench instantiates it alongside alu_sequencer.

Verification
REQ-034: LOAD r0=9, LOAD r1=8, ADD(0000) rd=2 ra=0 rb=1 -> EXEC alu_a=9, alu_b=8, alu_s=0000; rsp_data=5'd17; rf[2]=4'h1.
REQ-035: LOAD r0=3, LOAD r1=5, SUB(0001) rd=3 -> rsp_data=5'b11110; rf[3]=4'hE.
REQ-036: LOAD r1=7, ADD rd=1 ra=1 rb=1 -> rsp_data=5'd14; rf[1]=4'hE.
REQ-037: ALU command with rsp_ready=0 for 5 cycles, cmd_valid=1 throughout -> rsp_valid and rsp_data stable, cmd_ready=0, no second command taken until the handshake.
REQ-038: rst pulsed during EXEC of ADD rd=2 -> outputs at reset values in the same cycle, rf all 0, no rsp_valid afterwards.
REQ-039: ZERO(1111) rd=0 after LOAD r0=5 -> rsp_data=0; rf[0]=0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_seq_pkg : opcode constants and FSM state encoding for alu_sequencer
// Revision    : 1.0
// ----------------------------------------------------------------------------
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOTA = 4'b0101;
    localparam logic [3:0] OP_SHL  = 4'b0110;
    localparam logic [3:0] OP_SHR  = 4'b0111;
    localparam logic [3:0] OP_LOAD = 4'b1000;
    localparam logic [3:0] OP_ZERO = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_regfile.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_regfile : 4x4 register file, two async read ports, one sync write port
// Revision    : 1.0
// ----------------------------------------------------------------------------
module seq_regfile (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_we,
    input  logic [1:0] i_waddr,
    input  logic [3:0] i_wdata,
    input  logic [1:0] i_raddr_a,
    input  logic [1:0] i_raddr_b,
    output logic [3:0] o_rdata_a,
    output logic [3:0] o_rdata_b
);

    logic [3:0] r_mem [0:3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= 4'd0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_sequencer : issues register-file commands to an external ALU, writes back
//                 the result and returns it on a ready/valid response port
// Revision      : 1.0
// ----------------------------------------------------------------------------
module alu_sequencer
    import alu_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [1:0] cmd_rd,
    input  logic [1:0] cmd_ra,
    input  logic [1:0] cmd_rb,
    input  logic [3:0] cmd_imm,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_s,
    input  logic [4:0] alu_res,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [4:0] rsp_data
);

    state_t     r_state;
    logic [1:0] r_rd;
    logic [3:0] r_alu_a;
    logic [3:0] r_alu_b;
    logic [3:0] r_alu_s;
    logic [4:0] r_rsp_data;
    logic       r_rsp_valid;

    logic       w_accept;
    logic       w_is_load;
    logic       w_we;
    logic [1:0] w_waddr;
    logic [3:0] w_wdata;
    logic [3:0] w_rdata_a;
    logic [3:0] w_rdata_b;

    assign cmd_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_is_load = (cmd_op == OP_LOAD);

    // The only two write sources are a LOAD at accept time and the ALU result at EXEC end.
    assign w_we    = (w_accept && w_is_load) || (r_state == ST_EXEC);
    assign w_waddr = (r_state == ST_EXEC) ? r_rd : cmd_rd;
    assign w_wdata = (r_state == ST_EXEC) ? alu_res[3:0] : cmd_imm;

    seq_regfile u_rf (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata),
        .i_raddr_a (cmd_ra),
        .i_raddr_b (cmd_rb),
        .o_rdata_a (w_rdata_a),
        .o_rdata_b (w_rdata_b)
    );

    // Operands are captured at accept, so a same-command write-back cannot disturb them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rd        <= 2'd0;
            r_alu_a     <= 4'd0;
            r_alu_b     <= 4'd0;
            r_alu_s     <= OP_ZERO;
            r_rsp_data  <= 5'd0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_load) begin
                            r_rsp_data  <= {1'b0, cmd_imm};
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end else begin
                            r_rd    <= cmd_rd;
                            r_alu_a <= w_rdata_a;
                            r_alu_b <= w_rdata_b;
                            r_alu_s <= cmd_op;
                            r_state <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    r_rsp_data  <= alu_res;
                    r_rsp_valid <= 1'b1;
                    r_alu_a     <= 4'd0;
                    r_alu_b     <= 4'd0;
                    r_alu_s     <= OP_ZERO;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_s     = r_alu_s;
    assign rsp_data  = r_rsp_data;
    assign rsp_valid = r_rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_alu_sequencer : bench for alu_sequencer with an external behavioural ALU
// Revision         : 1.0
// ----------------------------------------------------------------------------
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [1:0] cmd_rd;
    logic [1:0] cmd_ra;
    logic [1:0] cmd_rb;
    logic [3:0] cmd_imm;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_s;
    logic [4:0] alu_res;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [4:0] rsp_data;

    int total = 0;
    int bad   = 0;
    logic [3:0] rf_m [0:3];

    function automatic logic [4:0] alu_ref(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
        case (s)
            OP_ADD:  alu_ref = {1'b0, a} + {1'b0, b};
            OP_SUB:  alu_ref = {1'b0, a} - {1'b0, b};
            OP_AND:  alu_ref = {1'b0, a & b};
            OP_OR:   alu_ref = {1'b0, a | b};
            OP_XOR:  alu_ref = {1'b0, a ^ b};
            OP_NOTA: alu_ref = {1'b0, ~a};
            OP_SHL:  alu_ref = {a, 1'b0};
            OP_SHR:  alu_ref = {2'b00, a[3:1]};
            OP_ZERO: alu_ref = 5'd0;
            default: alu_ref = {1'b0, a} + {1'b0, b} + 5'd1 + {1'b0, s};
        endcase
    endfunction

    assign alu_res = alu_ref(alu_s, alu_a, alu_b);

    alu_sequencer u_dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rd    (cmd_rd),
        .cmd_ra    (cmd_ra),
        .cmd_rb    (cmd_rb),
        .cmd_imm   (cmd_imm),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_s     (alu_s),
        .alu_res   (alu_res),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({cmd_ready, rsp_valid, rsp_data, alu_a, alu_b, alu_s} !== {1'b0, 1'b0, 5'd0, 4'd0, 4'd0, 4'hF}) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h a=%h b=%h s=%h want 0 0 00 0 0 f",
                     cmd_ready, rsp_valid, rsp_data, alu_a, alu_b, alu_s);
        end
        for (int i = 0; i < 4; i++) begin
            rf_m[i] = 4'd0;
            total++;
            if (u_dut.u_rf.r_mem[i] !== 4'd0) begin
                bad++;
                $display("FAIL reset_rf%0d: got %h want 0", i, u_dut.u_rf.r_mem[i]);
            end
        end
        rst = 1'b0;
    endtask

    // Runs one command end-to-end against the model; hold = stall cycles with cmd_valid high.
    task automatic do_cmd(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                          input logic [1:0] rb, input logic [3:0] imm, input int hold,
                          output logic [4:0] got);
        logic [4:0] exp;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm;
        rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = (hold > 0);
        if (op != OP_LOAD) begin
            total++;
            if ({alu_a, alu_b, alu_s, cmd_ready, rsp_valid} !== {rf_m[ra], rf_m[rb], op, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL exec_issue: got a=%h b=%h s=%h rdy=%b vld=%b want a=%h b=%h s=%h rdy=0 vld=0",
                         alu_a, alu_b, alu_s, cmd_ready, rsp_valid, rf_m[ra], rf_m[rb], op);
            end
            exp = alu_ref(op, rf_m[ra], rf_m[rb]);
            @(negedge clk);
        end else begin
            exp = {1'b0, imm};
        end
        rf_m[rd] = exp[3:0];
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp) begin
            bad++;
            $display("FAIL response: got vld=%b data=%h want vld=1 data=%h", rsp_valid, rsp_data, exp);
        end
        total++;
        if ({alu_a, alu_b, alu_s} !== {4'd0, 4'd0, 4'hF}) begin
            bad++;
            $display("FAIL alu_idle: got a=%h b=%h s=%h want 0 0 f", alu_a, alu_b, alu_s);
        end
        got = rsp_data;
        for (int i = 0; i < hold; i++) begin
            cmd_op = 4'($urandom); cmd_rd = 2'($urandom); cmd_ra = 2'($urandom);
            cmd_rb = 2'($urandom); cmd_imm = 4'($urandom);
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp || cmd_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold: got vld=%b data=%h rdy=%b want vld=1 data=%h rdy=0",
                         rsp_valid, rsp_data, cmd_ready, exp);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        total++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL handshake: got vld=%b rdy=%b want vld=0 rdy=1", rsp_valid, cmd_ready);
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (u_dut.u_rf.r_mem[i] !== rf_m[i]) begin
                bad++;
                $display("FAIL rf%0d: got %h want %h", i, u_dut.u_rf.r_mem[i], rf_m[i]);
            end
        end
    endtask

    task automatic test_directed();
        logic [4:0] got;
        do_cmd(OP_LOAD, 2'd0, 2'd0, 2'd0, 4'd9, 0, got);
        do_cmd(OP_LOAD, 2'd1, 2'd0, 2'd0, 4'd8, 0, got);
        do_cmd(OP_ADD, 2'd2, 2'd0, 2'd1, 4'd0, 0, got);
        total++;
        if (got !== 5'd17 || u_dut.u_rf.r_mem[2] !== 4'h1) begin
            bad++;
            $display("FAIL add_9_8: got data=%h rf2=%h want 11 1", got, u_dut.u_rf.r_mem[2]);
        end
        do_cmd(OP_LOAD, 2'd0, 2'd0, 2'd0, 4'd3, 0, got);
        do_cmd(OP_LOAD, 2'd1, 2'd0, 2'd0, 4'd5, 0, got);
        do_cmd(OP_SUB, 2'd3, 2'd0, 2'd1, 4'd0, 0, got);
        total++;
        if (got !== 5'b11110 || u_dut.u_rf.r_mem[3] !== 4'hE) begin
            bad++;
            $display("FAIL sub_3_5: got data=%h rf3=%h want 1e e", got, u_dut.u_rf.r_mem[3]);
        end
        do_cmd(OP_LOAD, 2'd1, 2'd0, 2'd0, 4'd7, 0, got);
        do_cmd(OP_ADD, 2'd1, 2'd1, 2'd1, 4'd0, 0, got);
        total++;
        if (got !== 5'd14 || u_dut.u_rf.r_mem[1] !== 4'hE) begin
            bad++;
            $display("FAIL add_self: got data=%h rf1=%h want 0e e", got, u_dut.u_rf.r_mem[1]);
        end
        do_cmd(OP_LOAD, 2'd0, 2'd0, 2'd0, 4'd5, 0, got);
        do_cmd(OP_ZERO, 2'd0, 2'd0, 2'd1, 4'd0, 0, got);
        total++;
        if (got !== 5'd0 || u_dut.u_rf.r_mem[0] !== 4'h0) begin
            bad++;
            $display("FAIL zero_op: got data=%h rf0=%h want 00 0", got, u_dut.u_rf.r_mem[0]);
        end
    endtask

    task automatic test_stall();
        logic [4:0] got;
        do_cmd(OP_LOAD, 2'd2, 2'd0, 2'd0, 4'd6, 3, got);
        do_cmd(OP_ADD, 2'd3, 2'd2, 2'd1, 4'd0, 5, got);
    endtask

    task automatic test_rsp_ready_idle();
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || u_dut.u_rf.r_mem[i] !== rf_m[i]) begin
                bad++;
                $display("FAIL ready_in_idle: got vld=%b rdy=%b rf%0d=%h want 0 1 %h",
                         rsp_valid, cmd_ready, i, u_dut.u_rf.r_mem[i], rf_m[i]);
            end
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_exec();
        logic [4:0] got;
        do_cmd(OP_LOAD, 2'd0, 2'd0, 2'd0, 4'd9, 0, got);
        do_cmd(OP_LOAD, 2'd1, 2'd0, 2'd0, 4'd8, 0, got);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_rd = 2'd2; cmd_ra = 2'd0; cmd_rb = 2'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        total++;
        if (alu_a !== 4'd9 || alu_b !== 4'd8) begin
            bad++;
            $display("FAIL rst_exec_issue: got a=%h b=%h want 9 8", alu_a, alu_b);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({cmd_ready, rsp_valid, rsp_data, alu_a, alu_b, alu_s} !== {1'b0, 1'b0, 5'd0, 4'd0, 4'd0, 4'hF}) begin
            bad++;
            $display("FAIL rst_exec_async: got rdy=%b vld=%b data=%h a=%h b=%h s=%h want 0 0 00 0 0 f",
                     cmd_ready, rsp_valid, rsp_data, alu_a, alu_b, alu_s);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) rf_m[i] = 4'd0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b0 || u_dut.u_rf.r_mem[2] !== 4'd0 || u_dut.u_rf.r_mem[0] !== 4'd0) begin
                bad++;
                $display("FAIL rst_exec_after: got vld=%b rf0=%h rf2=%h want 0 0 0",
                         rsp_valid, u_dut.u_rf.r_mem[0], u_dut.u_rf.r_mem[2]);
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] got;
        for (int n = 0; n < 40; n++) begin
            do_cmd(4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom), 2'($urandom),
                   4'($urandom), int'($urandom_range(0, 2)), got);
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = 4'd0; cmd_rd = 2'd0; cmd_ra = 2'd0; cmd_rb = 2'd0;
        cmd_imm = 4'd0; rsp_ready = 1'b0;
        test_reset();
        test_directed();
        test_stall();
        test_rsp_ready_idle();
        test_reset_exec();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
